instr_fetch_ctrl: RTL and testbench

Fetch sequencer for the multi-cycle 16-bit processor. Owns the instruction pointer and drives the instruction memory's IPR write/address port. Captures each returned instruction into a holding register and presents it to the control unit over a valid/ready handshake. Supports pointer redirect for branches and jumps, a run/stop gate, and an optional halt-opcode detector.

---
 rtl/ifc_pkg.sv | 19 +
 rtl/instr_fetch_ctrl_if.sv | 30 +++
 rtl/ifc_ptr_reg.sv | 25 ++
 rtl/instr_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifc_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state encoding,
// opcode field position and the default halt opcode.
package ifc_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      VALID = 3'd3,
      HALT  = 3'd4
   } ifc_state_t;

   localparam int unsigned OPC_MSB = 15;
   localparam int unsigned OPC_LSB = 12;
   localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

   localparam logic [OPC_W-1:0] IFC_HALT_OPCODE_DEFAULT = 4'hF;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer, the instruction memory IPR port
// and the control unit. master = fetch sequencer, slave = memory/control side.
interface instr_fetch_ctrl_if #(
   parameter int unsigned INSTRUCTION_LEN      = 16,
   parameter int unsigned INSTRUCTION_MEM_SIZE = 8
);

   logic                            run;
   logic                            ipr_write;
   logic [INSTRUCTION_MEM_SIZE-1:0] instruction_ptr;
   logic [INSTRUCTION_LEN-1:0]      instruction;
   logic [INSTRUCTION_LEN-1:0]      instr_out;
   logic                            instr_valid;
   logic                            instr_ready;
   logic [INSTRUCTION_MEM_SIZE-1:0] instr_pc;
   logic                            redirect_valid;
   logic [INSTRUCTION_MEM_SIZE-1:0] redirect_ptr;
   logic                            halted;

   modport master (
      input  run, instruction, instr_ready, redirect_valid, redirect_ptr,
      output ipr_write, instruction_ptr, instr_out, instr_valid, instr_pc, halted
   );

   modport slave (
      output run, instruction, instr_ready, redirect_valid, redirect_ptr,
      input  ipr_write, instruction_ptr, instr_out, instr_valid, instr_pc, halted
   );

endinterface

// File: rtl/ifc_ptr_reg.sv
// Instruction pointer register: load beats increment; with neither asserted
// the pointer holds. Increment wraps modulo 2**WIDTH.
module ifc_ptr_reg #(
   parameter int unsigned     WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             inc,
   output logic [WIDTH-1:0] ptr
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= RESET_VAL;
      end else if (load) begin
         ptr <= load_val;
      end else if (inc) begin
         ptr <= ptr + WIDTH'(1);
      end
   end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: issues IPR loads, captures returned instructions and hands
// them to the control unit over valid/ready. Optional halt detect: IFC_HALT_DETECT_EN.
module instr_fetch_ctrl
   import ifc_pkg::*;
#(
   parameter int unsigned         INSTRUCTION_LEN      = 16,
   parameter int unsigned         INSTRUCTION_MEM_SIZE = 8,
   parameter int unsigned         IPR_SIZE             = 8,
   parameter logic [IPR_SIZE-1:0] RESET_PTR            = '0,
   parameter logic [OPC_W-1:0]    HALT_OPCODE          = IFC_HALT_OPCODE_DEFAULT
) (
   input logic                clk,
   input logic                rst,
   instr_fetch_ctrl_if.master bus
);

   ifc_state_t                 state_q, state_d;
   logic [IPR_SIZE-1:0]        pc;
   logic                       ptr_load;
   logic                       ptr_inc;
   logic                       capture;
   logic [INSTRUCTION_LEN-1:0] instr_q;
   logic [IPR_SIZE-1:0]        pc_q;

   ifc_ptr_reg #(
      .WIDTH     (IPR_SIZE),
      .RESET_VAL (RESET_PTR)
   ) u_ptr (
      .clk      (clk),
      .rst      (rst),
      .load     (ptr_load),
      .load_val (bus.redirect_ptr),
      .inc      (ptr_inc),
      .ptr      (pc)
   );

`ifdef IFC_HALT_DETECT_EN
   logic halt_hit;
   assign halt_hit   = (instr_q[OPC_MSB:OPC_LSB] == HALT_OPCODE);
   assign bus.halted = (state_q == HALT);
`else
   logic unused_halt_opcode;
   assign unused_halt_opcode = ^HALT_OPCODE;
   assign bus.halted         = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Redirect always reloads the pointer; a redirect during ISSUE re-issues so
   // the captured pc never disagrees with the address actually presented.
   always_comb begin
      state_d  = state_q;
      ptr_load = bus.redirect_valid;
      ptr_inc  = 1'b0;
      capture  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.run) state_d = ISSUE;
         end
         ISSUE: begin
            state_d = bus.redirect_valid ? ISSUE : WAIT;
         end
         WAIT: begin
            if (bus.redirect_valid) begin
               state_d = ISSUE;
            end else begin
               capture = 1'b1;
               state_d = VALID;
            end
         end
         VALID: begin
            if (bus.redirect_valid) begin
               state_d = ISSUE;
            end else if (bus.instr_ready) begin
`ifdef IFC_HALT_DETECT_EN
               if (halt_hit) begin
                  state_d = HALT;
               end else begin
                  ptr_inc = 1'b1;
                  state_d = bus.run ? ISSUE : IDLE;
               end
`else
               ptr_inc = 1'b1;
               state_d = bus.run ? ISSUE : IDLE;
`endif
            end
         end
`ifdef IFC_HALT_DETECT_EN
         HALT: begin
            if (bus.redirect_valid) state_d = ISSUE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_q <= '0;
         pc_q    <= '0;
      end else if (capture) begin
         instr_q <= bus.instruction;
         pc_q    <= pc;
      end
   end

   assign bus.ipr_write       = (state_q == ISSUE);
   assign bus.instruction_ptr = pc;
   assign bus.instr_valid     = (state_q == VALID);
   assign bus.instr_out       = instr_q;
   assign bus.instr_pc        = pc_q;

   a_valid_held: assert property (@(posedge clk) disable iff (!rst)
      (bus.instr_valid && !bus.instr_ready && !bus.redirect_valid) |=> bus.instr_valid);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: cycle vector table plus
// scoreboarded multi-cycle sequences on two instances (RESET_PTR 0 and 254).
module tb_instr_fetch_ctrl;

   typedef struct {
      logic        run;
      logic        rdy;
      logic        rv;
      logic [7:0]  rptr;
      logic        exp_w;
      logic [7:0]  exp_ptr;
      logic        exp_v;
      logic [15:0] exp_out;
      logic [7:0]  exp_pc;
   } vec_t;

   typedef struct {
      logic [15:0] instr;
      logic [7:0]  pc;
   } exp_t;

   logic clk;
   logic rst;

   int checks = 0;
   int errors = 0;

   exp_t q_a[$];
   exp_t q_b[$];
   bit   auto_stop_a = 0;
   bit   auto_stop_b = 0;
   bit   count_b     = 0;
   bit   prev_w_b    = 0;
   int   pulses_b    = 0;
   int   doubles_b   = 0;

   vec_t vecs[25];

   instr_fetch_ctrl_if #(.INSTRUCTION_LEN(16), .INSTRUCTION_MEM_SIZE(8)) bus_a ();
   instr_fetch_ctrl_if #(.INSTRUCTION_LEN(16), .INSTRUCTION_MEM_SIZE(8)) bus_b ();

   instr_fetch_ctrl #(.RESET_PTR(8'd0)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   instr_fetch_ctrl #(.RESET_PTR(8'd254)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   // Instruction memories with their IPR address registers
   logic [15:0] mem_a [256];
   logic [15:0] mem_b [256];
   logic [7:0]  ipr_a, ipr_b;

   always @(posedge clk) begin
      if (bus_a.ipr_write) ipr_a <= bus_a.instruction_ptr;
      if (bus_b.ipr_write) ipr_b <= bus_b.instruction_ptr;
   end
   assign bus_a.instruction = mem_a[ipr_a];
   assign bus_b.instruction = mem_b[ipr_b];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_a(input logic [15:0] instr, input logic [7:0] pc);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      q_a.push_back(e);
   endtask

   task automatic push_b(input logic [15:0] instr, input logic [7:0] pc);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      q_b.push_back(e);
   endtask

   // One clock: scoreboard handshakes at the falling edge, return at posedge+1
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (bus_a.instr_valid && bus_a.instr_ready) begin
         checks++;
         if (q_a.size() == 0) begin
            errors++;
            $display("FAIL sb_a_unexpected: got instr %0h pc %0h expected no handshake",
                     bus_a.instr_out, bus_a.instr_pc);
         end else begin
            e = q_a.pop_front();
            chk("sb_a_instr", bus_a.instr_out, e.instr);
            chk("sb_a_pc", bus_a.instr_pc, e.pc);
            if (auto_stop_a && q_a.size() == 0) bus_a.run = 1'b0;
         end
      end
      if (bus_b.instr_valid && bus_b.instr_ready) begin
         checks++;
         if (q_b.size() == 0) begin
            errors++;
            $display("FAIL sb_b_unexpected: got instr %0h pc %0h expected no handshake",
                     bus_b.instr_out, bus_b.instr_pc);
         end else begin
            e = q_b.pop_front();
            chk("sb_b_instr", bus_b.instr_out, e.instr);
            chk("sb_b_pc", bus_b.instr_pc, e.pc);
            if (auto_stop_b && q_b.size() == 0) bus_b.run = 1'b0;
         end
      end
      if (count_b) begin
         if (bus_b.ipr_write) begin
            pulses_b++;
            if (prev_w_b) doubles_b++;
         end
         prev_w_b = bus_b.ipr_write;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain_a(input int bound);
      for (int i = 0; i < bound && q_a.size() != 0; i++) tick();
      chk("drain_a_pending", q_a.size(), 0);
   endtask

   task automatic drain_b(input int bound);
      for (int i = 0; i < bound && q_b.size() != 0; i++) tick();
      chk("drain_b_pending", q_b.size(), 0);
   endtask

   function automatic vec_t mk(input logic run, input logic rdy, input logic rv,
                               input logic [7:0] rptr, input logic w, input logic [7:0] ptr,
                               input logic v, input logic [15:0] out, input logic [7:0] pc);
      vec_t r;
      r.run = run; r.rdy = rdy; r.rv = rv; r.rptr = rptr;
      r.exp_w = w; r.exp_ptr = ptr; r.exp_v = v; r.exp_out = out; r.exp_pc = pc;
      return r;
   endfunction

   initial begin
      for (int j = 0; j < 256; j++) begin
         mem_a[j] = 16'(j);
         mem_b[j] = 16'(j);
      end
      rst = 1'b0;
      bus_a.run = 1'b0; bus_a.instr_ready = 1'b0;
      bus_a.redirect_valid = 1'b0; bus_a.redirect_ptr = '0;
      bus_b.run = 1'b0; bus_b.instr_ready = 1'b1;
      bus_b.redirect_valid = 1'b0; bus_b.redirect_ptr = '0;

      //          run rdy rv rptr  | w  ptr   v  out      pc
      vecs[0]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00);
      vecs[1]  = mk(1, 1, 0, 8'h00, 1, 8'h00, 0, 16'h0000, 8'h00);
      vecs[2]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 16'h0000, 8'h00);
      vecs[3]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 1, 16'h0000, 8'h00);
      vecs[4]  = mk(1, 0, 0, 8'h00, 1, 8'h01, 0, 16'h0000, 8'h00);
      vecs[5]  = mk(1, 0, 0, 8'h00, 0, 8'h01, 0, 16'h0000, 8'h00);
      vecs[6]  = mk(0, 0, 0, 8'h00, 0, 8'h01, 1, 16'h0001, 8'h01);
      vecs[7]  = mk(0, 0, 0, 8'h00, 0, 8'h01, 1, 16'h0001, 8'h01);
      vecs[8]  = mk(0, 0, 0, 8'h00, 0, 8'h01, 1, 16'h0001, 8'h01);
      vecs[9]  = mk(0, 1, 0, 8'h00, 0, 8'h01, 1, 16'h0001, 8'h01);
      vecs[10] = mk(0, 0, 0, 8'h00, 0, 8'h02, 0, 16'h0001, 8'h01);
      vecs[11] = mk(0, 0, 1, 8'h30, 0, 8'h02, 0, 16'h0001, 8'h01);
      vecs[12] = mk(1, 0, 0, 8'h00, 0, 8'h30, 0, 16'h0001, 8'h01);
      vecs[13] = mk(1, 0, 0, 8'h00, 1, 8'h30, 0, 16'h0001, 8'h01);
      vecs[14] = mk(1, 0, 1, 8'h40, 0, 8'h30, 0, 16'h0001, 8'h01);
      vecs[15] = mk(1, 0, 0, 8'h00, 1, 8'h40, 0, 16'h0001, 8'h01);
      vecs[16] = mk(1, 0, 0, 8'h00, 0, 8'h40, 0, 16'h0001, 8'h01);
      vecs[17] = mk(1, 1, 1, 8'h60, 0, 8'h40, 1, 16'h0040, 8'h40);
      vecs[18] = mk(1, 0, 0, 8'h00, 1, 8'h60, 0, 16'h0040, 8'h40);
      vecs[19] = mk(1, 0, 0, 8'h00, 0, 8'h60, 0, 16'h0040, 8'h40);
      vecs[20] = mk(1, 0, 1, 8'h20, 0, 8'h60, 1, 16'h0060, 8'h60);
      vecs[21] = mk(0, 0, 0, 8'h00, 1, 8'h20, 0, 16'h0060, 8'h60);
      vecs[22] = mk(0, 0, 0, 8'h00, 0, 8'h20, 0, 16'h0060, 8'h60);
      vecs[23] = mk(0, 1, 0, 8'h00, 0, 8'h20, 1, 16'h0020, 8'h20);
      vecs[24] = mk(0, 0, 0, 8'h00, 0, 8'h21, 0, 16'h0020, 8'h20);

      // Reset values
      #12;
      chk("rst_ipr_write", bus_a.ipr_write, 0);
      chk("rst_iptr_a", bus_a.instruction_ptr, 8'h00);
      chk("rst_iptr_b", bus_b.instruction_ptr, 8'hFE);
      chk("rst_valid", bus_a.instr_valid, 0);
      chk("rst_out", bus_a.instr_out, 0);
      chk("rst_pc", bus_a.instr_pc, 0);
      chk("rst_halted", bus_a.halted, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Cycle vectors: fetch, backpressure, redirects in IDLE/WAIT/VALID
      push_a(16'h0000, 8'h00);
      push_a(16'h0001, 8'h01);
      push_a(16'h0040, 8'h40);
      push_a(16'h0020, 8'h20);
      for (int i = 0; i < 25; i++) begin
         bus_a.run            = vecs[i].run;
         bus_a.instr_ready    = vecs[i].rdy;
         bus_a.redirect_valid = vecs[i].rv;
         bus_a.redirect_ptr   = vecs[i].rptr;
         chk($sformatf("v%0d_ipr_write", i), bus_a.ipr_write, vecs[i].exp_w);
         chk($sformatf("v%0d_iptr", i), bus_a.instruction_ptr, vecs[i].exp_ptr);
         chk($sformatf("v%0d_valid", i), bus_a.instr_valid, vecs[i].exp_v);
         chk($sformatf("v%0d_out", i), bus_a.instr_out, vecs[i].exp_out);
         chk($sformatf("v%0d_pc", i), bus_a.instr_pc, vecs[i].exp_pc);
         tick();
      end
      bus_a.run = 1'b0; bus_a.instr_ready = 1'b0; bus_a.redirect_valid = 1'b0;
      chk("table_sb_left", q_a.size(), 0);

      // Wrap on the RESET_PTR=254 instance
      push_b(16'h00FE, 8'hFE);
      push_b(16'h00FF, 8'hFF);
      push_b(16'h0000, 8'h00);
      push_b(16'h0001, 8'h01);
      auto_stop_b = 1; count_b = 1;
      bus_b.run = 1'b1;
      drain_b(40);
      for (int i = 0; i < 4; i++) tick();
      chk("wrap_ipr_pulses", pulses_b, 4);
      chk("wrap_ipr_double", doubles_b, 0);
      count_b = 0;

      // Backpressure: 10 cycles held in VALID
      auto_stop_a = 1;
      push_a(16'h0021, 8'h21);
      push_a(16'h0022, 8'h22);
      bus_a.run = 1'b1;
      for (int i = 0; i < 10 && !bus_a.instr_valid; i++) tick();
      chk("bp_valid_seen", bus_a.instr_valid, 1);
      for (int i = 0; i < 10; i++) begin
         chk("bp_ipr_write", bus_a.ipr_write, 0);
         chk("bp_out", bus_a.instr_out, 16'h0021);
         chk("bp_pc", bus_a.instr_pc, 8'h21);
         tick();
      end
      bus_a.instr_ready = 1'b1;
      drain_a(20);

      // Reset in the middle of a fetch
      bus_a.run = 1'b1;
      for (int i = 0; i < 6 && !bus_a.ipr_write; i++) tick();
      chk("mid_issue_seen", bus_a.ipr_write, 1);
      chk("mid_issue_ptr", bus_a.instruction_ptr, 8'h23);
      tick();
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_ipr_write", bus_a.ipr_write, 0);
      chk("mid_rst_iptr", bus_a.instruction_ptr, 8'h00);
      chk("mid_rst_valid", bus_a.instr_valid, 0);
      chk("mid_rst_out", bus_a.instr_out, 0);
      chk("mid_rst_pc", bus_a.instr_pc, 0);
      chk("mid_rst_halted", bus_a.halted, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      push_a(16'h0000, 8'h00);
      for (int i = 0; i < 6 && !bus_a.ipr_write; i++) tick();
      chk("restart_ptr", bus_a.instruction_ptr, 8'h00);
      drain_a(20);

      // Halt opcode at address 3
      mem_a[3] = 16'hF000;
      push_a(16'h0001, 8'h01);
      push_a(16'h0002, 8'h02);
      push_a(16'hF000, 8'h03);
`ifdef IFC_HALT_DETECT_EN
      bus_a.run = 1'b1;
      drain_a(30);
      bus_a.run = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("halt_halted", bus_a.halted, 1);
         chk("halt_ipr_write", bus_a.ipr_write, 0);
         tick();
      end
      push_a(16'h0010, 8'h10);
      bus_a.run = 1'b0;
      bus_a.redirect_valid = 1'b1;
      bus_a.redirect_ptr = 8'h10;
      tick();
      bus_a.redirect_valid = 1'b0;
      chk("resume_halted", bus_a.halted, 0);
      chk("resume_ipr_write", bus_a.ipr_write, 1);
      chk("resume_ptr", bus_a.instruction_ptr, 8'h10);
      drain_a(20);
`else
      push_a(16'h0004, 8'h04);
      bus_a.run = 1'b1;
      drain_a(40);
      chk("nohalt_halted", bus_a.halted, 0);
`endif
      mem_a[3] = 16'h0003;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
